ram_port_master: RTL
====================

Name: ram_port_master

Overview:
- Initiator-side controller for the 8x128 single-port RAM.
- Accepts independent write and read requests over valid/ready channels and arbitrates them onto the single RAM port, one command per cycle.
- Returns read data in request order through a buffered valid/ready response channel.
- Sits between client logic and the RAM. It drives data_in, wr_en and addr, and consumes data_out.

Parameters:
ADDR_W, 3, RAM address width (depth 2**ADDR_W)
DATA_W, 128, RAM word width
RSP_DEPTH, 4, read-response FIFO entries; power of two, >=2

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
wr_req_valid  in  1  write request present
wr_req_ready  out  1  write request accepted this cycle
wr_req_addr  in  ADDR_W  write address
wr_req_data  in  DATA_W  write data
rd_req_valid  in  1  read request present
rd_req_ready  out  1  read request accepted this cycle
rd_req_addr  in  ADDR_W  read address
rd_rsp_valid  out  1  read data available
rd_rsp_ready  in  1  consumer takes read data
rd_rsp_data  out  DATA_W  read data, in request order
ram_wr_en  out  1  to RAM wr_en
ram_addr  out  ADDR_W  to RAM addr
ram_data_in  out  DATA_W  to RAM data_in
ram_data_out  in  DATA_W  from RAM data_out; valid the cycle after addr is presented
busy  out  1  any command, capture or response in flight

Behaviour:
- Reset values: wr_req_ready=0, rd_req_ready=0, rd_rsp_valid=0, rd_rsp_data=0, ram_wr_en=0, ram_addr=0, ram_data_in=0, busy=0. All of these hold for the entire time rst is high.
- Handshake: a transfer occurs when valid&ready are both high at a rising edge. The requester must hold addr and data stable while valid is high and ready is low.
- At most one request (write or read) is accepted per cycle. The accepted request loads the command register (op, addr, data).
- Command stage: in cycle T+1 after acceptance in T, the registered outputs are driven:
  - ram_addr = cmd_addr
  - ram_data_in = cmd_data
  - ram_wr_en = cmd_valid & cmd_is_wr
  - The command register drains every cycle, so there is no stall.
  - With no command, ram_wr_en=0 and ram_addr/ram_data_in hold their last value.
- Read pipeline timing:
  - accept in T; RAM latches read address at the end of T+1
  - ram_data_out valid in T+2 and captured into the response FIFO at the end of T+2
  - rd_rsp_valid high from T+3
  - Response latency: 3 cycles with an empty FIFO.
- Credit rule: outstanding = fifo_count + cmd_is_rd + capture_pending.
  - rd eligible when outstanding < RSP_DEPTH.
  - A pop in the same cycle is not counted as a credit.
  - No response is ever dropped or overwritten.
- Write eligibility: always eligible (no response).
- Arbitration, round-robin between write and read:
  - If only one is valid and eligible, grant it.
  - If both are valid and eligible, grant the one not granted last.
  - After reset the last grant is read, so write wins the first tie.
  - An ineligible read never blocks a write.
  - ready is asserted only for the granted channel and is combinational from valid, credit and the RR pointer.
- Ordering: commands issue in acceptance order.
  - A read accepted after a write to the same address returns the new data.
  - Because the RAM is write-first on a same-cycle write and read-address update, no hazard logic is needed.
- Response FIFO:
  - push on capture, pop on rd_rsp_valid&rd_rsp_ready
  - simultaneous push and pop on a non-empty FIFO leaves the count unchanged
  - rd_rsp_data is the FIFO head (registered storage)
- Address wrap: addresses are taken as-is, 7 then 0 is legal, and there is no range check.
- busy = cmd_valid | capture_pending | (fifo_count != 0).
- Reset mid-operation: the command register, capture flag, FIFO and RR pointer are cleared and in-flight reads are discarded. ram_wr_en drops immediately (asynchronously), so no partial write is issued after rst rises. RAM contents are not cleared.

Decomposition:
- Shared package: ADDR_W/DATA_W defaults; op encoding constant (OP_WR=1'b1, OP_RD=1'b0); RSP_DEPTH default.
- Sub-module: ram_rsp_fifo, a synchronous FIFO parameterized by DATA_W and RSP_DEPTH, with push/pop/count, asynchronous active-high reset, and no overflow or underflow by construction.
- Arbiter, command register and credit logic stay in the top module.

Test Plan:
- Write addr 3 = 0x0123...CDEF, then read addr 3 with rd_rsp_ready=1 -> ram_wr_en is a single pulse with ram_addr=3. rd_rsp_valid rises exactly 3 cycles after the read accept, with rd_rsp_data=0x0123...CDEF.
- Fill addr 0..7 with value=addr, then read 7,0,1 back-to-back -> responses 7,0,1 in order; wrap from 7 to 0 causes no error.
- rd_rsp_ready=0, issue 6 reads -> exactly 4 accepted, then rd_req_ready=0. Set rd_rsp_ready=1 -> 4 responses in order, then the remaining 2 accepted and returned; no loss or duplication.
- wr_req_valid and rd_req_valid held high for 6 cycles -> grants alternate W,R,W,R,W,R starting with write. With the FIFO full, writes are granted every cycle.
- Write addr 5=A, then immediately read addr 5 next cycle -> response = A.
- Assert rst while 2 reads are in flight -> all outputs 0 asynchronously and no response is emitted after release. A subsequent read of an earlier-written address returns its pre-reset contents.

Source files
------------

// File: rtl/ram_port_master_pkg.sv
// Shared constants for the ram_port_master slice: default widths, response depth,
// command op encoding and the round-robin grant type.
package ram_port_master_pkg;
   localparam int ADDR_W_DEF    = 3;
   localparam int DATA_W_DEF    = 128;
   localparam int RSP_DEPTH_DEF = 4;

   localparam logic OP_WR = 1'b1;
   localparam logic OP_RD = 1'b0;

   typedef enum logic {GNT_RD = 1'b0, GNT_WR = 1'b1} gnt_e;
endpackage

// File: rtl/ram_rsp_fifo.sv
// Read-response FIFO with registered storage; head is visible the cycle after push.
// No internal flow control: the caller's credit scheme keeps push/pop within bounds.
module ram_rsp_fifo
   import ram_port_master_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = RSP_DEPTH_DEF,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;

   // Storage is reset too so the head reads as zero until the first capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];
endmodule

// File: rtl/ram_port_master.sv
// Arbitrates write/read requests onto the single-port RAM, one command per cycle; reads return in order 3 cycles after accept.
// Reads are credit-limited to the response FIFO depth so rd_rsp_ready backpressure never loses data; writes never stall.
module ram_port_master
   import ram_port_master_pkg::*;
#(
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int DATA_W    = DATA_W_DEF,
   parameter int RSP_DEPTH = RSP_DEPTH_DEF
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_req_valid,
   output logic              wr_req_ready,
   input  logic [ADDR_W-1:0] wr_req_addr,
   input  logic [DATA_W-1:0] wr_req_data,
   input  logic              rd_req_valid,
   output logic              rd_req_ready,
   input  logic [ADDR_W-1:0] rd_req_addr,
   output logic              rd_rsp_valid,
   input  logic              rd_rsp_ready,
   output logic [DATA_W-1:0] rd_rsp_data,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out,
   output logic              busy
);
   localparam int CW = $clog2(RSP_DEPTH) + 1;
   localparam int OW = CW + 1;
   localparam logic [OW-1:0] DEPTH_V = OW'(RSP_DEPTH);

   logic          cmd_valid;
   logic          cmd_op;
   logic          cap_pend;
   gnt_e          last_gnt;
   logic [CW-1:0] fifo_count;
   logic [OW-1:0] outstanding;
   logic          cmd_is_rd;
   logic          rd_ok;
   logic          gnt_wr;
   logic          gnt_rd;
   logic          rsp_pop;

   // Every read between accept and pop holds one credit: command stage, capture stage, FIFO.
   assign cmd_is_rd   = cmd_valid & (cmd_op == OP_RD);
   assign outstanding = {1'b0, fifo_count} + OW'(cmd_is_rd) + OW'(cap_pend);
   assign rd_ok       = rd_req_valid & (outstanding < DEPTH_V);

   assign gnt_wr = wr_req_valid & (~rd_ok | (last_gnt == GNT_RD));
   assign gnt_rd = rd_ok & (~wr_req_valid | (last_gnt == GNT_WR));

   assign wr_req_ready = gnt_wr & ~rst;
   assign rd_req_ready = gnt_rd & ~rst;

   // The command register doubles as the RAM output register, so it drains every cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd_valid   <= 1'b0;
         cmd_op      <= OP_RD;
         ram_addr    <= '0;
         ram_data_in <= '0;
         cap_pend    <= 1'b0;
         last_gnt    <= GNT_RD;
      end else begin
         cmd_valid <= wr_req_ready | rd_req_ready;
         cap_pend  <= cmd_is_rd;
         if (wr_req_ready) begin
            cmd_op      <= OP_WR;
            ram_addr    <= wr_req_addr;
            ram_data_in <= wr_req_data;
            last_gnt    <= GNT_WR;
         end else if (rd_req_ready) begin
            cmd_op   <= OP_RD;
            ram_addr <= rd_req_addr;
            last_gnt <= GNT_RD;
         end
      end
   end

   assign ram_wr_en    = cmd_valid & (cmd_op == OP_WR);
   assign rd_rsp_valid = (fifo_count != '0);
   assign rsp_pop      = rd_rsp_valid & rd_rsp_ready;
   assign busy         = cmd_valid | cap_pend | (fifo_count != '0);

   ram_rsp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cap_pend),
      .push_data (ram_data_out),
      .pop       (rsp_pop),
      .head      (rd_rsp_data),
      .count     (fifo_count)
   );
endmodule
